// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and codes for the data-memory load/store controller.
// Function codes follow the RV32I load/store func3 field.
package data_mem_ctrl_pkg;
  localparam int DATA_WIDTH  = 32;
  localparam int FUNC3_WIDTH = 3;

  localparam logic [FUNC3_WIDTH-1:0] F3_LB  = 3'b000;
  localparam logic [FUNC3_WIDTH-1:0] F3_LH  = 3'b001;
  localparam logic [FUNC3_WIDTH-1:0] F3_LW  = 3'b010;
  localparam logic [FUNC3_WIDTH-1:0] F3_LBU = 3'b100;
  localparam logic [FUNC3_WIDTH-1:0] F3_LHU = 3'b101;
  localparam logic [FUNC3_WIDTH-1:0] F3_SB  = 3'b000;
  localparam logic [FUNC3_WIDTH-1:0] F3_SH  = 3'b001;
  localparam logic [FUNC3_WIDTH-1:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERR
  } state_e;
endpackage

// File: rtl/data_mem_ctrl_if.sv
// Core request, BRAM port and load-result signals of the data-memory controller.
interface data_mem_ctrl_if #(
  parameter int ADDR_WIDTH      = 32,
  parameter int BRAM_ADDR_WIDTH = 10
);
  import data_mem_ctrl_pkg::*;

  logic                       req_valid;
  logic                       req_ready;
  logic                       req_store;
  logic [FUNC3_WIDTH-1:0]     req_func3;
  logic [ADDR_WIDTH-1:0]      req_addr;
  logic [DATA_WIDTH-1:0]      req_wdata;
  logic                       bram_en;
  logic [3:0]                 bram_we;
  logic [BRAM_ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0]      bram_wdata;
  logic [DATA_WIDTH-1:0]      bram_rdata;
  logic [DATA_WIDTH-1:0]      ld_data;
  logic [3:0]                 byte_mask;
  logic                       done;
  logic                       misaligned;
  logic                       busy;

  modport slave (
    input  req_valid, req_store, req_func3, req_addr, req_wdata, bram_rdata,
    output req_ready, bram_en, bram_we, bram_addr, bram_wdata,
           ld_data, byte_mask, done, misaligned, busy
  );

  modport master (
    output req_valid, req_store, req_func3, req_addr, req_wdata, bram_rdata,
    input  req_ready, bram_en, bram_we, bram_addr, bram_wdata,
           ld_data, byte_mask, done, misaligned, busy
  );
endinterface

// File: rtl/data_mem_ctrl_lsu_mask_gen.sv
// Byte-lane mask, alignment check and lane shift for one access.
// Shared by the store-data path and the load mask handed to the byte reader.
module lsu_mask_gen
  import data_mem_ctrl_pkg::*;
(
  input  logic [FUNC3_WIDTH-1:0] func3_i,
  input  logic [1:0]             addr_lo_i,
  output logic [3:0]             mask_o,
  output logic                   misaligned_o,
  output logic [4:0]             shift_o
);
  always_comb begin
    mask_o       = 4'b0000;
    misaligned_o = 1'b0;
    shift_o      = {addr_lo_i, 3'b000};
    case (func3_i)
      F3_LB, F3_LBU: mask_o = 4'b0001 << addr_lo_i;
      F3_LH, F3_LHU: begin
        mask_o       = 4'b0011 << addr_lo_i;
        misaligned_o = addr_lo_i[0];
      end
      F3_LW: begin
        mask_o       = 4'b1111;
        misaligned_o = |addr_lo_i;
      end
      default: misaligned_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store sequencer between the core and the data BRAM.
// One access in flight; all request fields are captured at accept.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int BRAM_LATENCY    = 1
)(
  input logic            clk,
  input logic            rst,
  data_mem_ctrl_if.slave bus
);
  state_e                     state_q;
  logic                       store_q;
  logic [1:0]                 cnt_q;
  logic                       req_ready_q;
  logic                       bram_en_q;
  logic [3:0]                 bram_we_q;
  logic [BRAM_ADDR_WIDTH-1:0] bram_addr_q;
  logic [DATA_WIDTH-1:0]      bram_wdata_q;
  logic [DATA_WIDTH-1:0]      ld_data_q;
  logic [3:0]                 byte_mask_q;
  logic                       done_q;
  logic                       misaligned_q;
  logic                       busy_q;

  logic [3:0] mask;
  logic       mis;
  logic [4:0] shift;

  // Address bits above the BRAM word range wrap silently.
  logic unused_addr;
  assign unused_addr = ^bus.req_addr[ADDR_WIDTH-1:BRAM_ADDR_WIDTH+2];

  lsu_mask_gen u_mask (
    .func3_i      (bus.req_func3),
    .addr_lo_i    (bus.req_addr[1:0]),
    .mask_o       (mask),
    .misaligned_o (mis),
    .shift_o      (shift)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      store_q      <= 1'b0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      bram_en_q    <= 1'b0;
      bram_we_q    <= '0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      ld_data_q    <= '0;
      byte_mask_q  <= '0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      bram_en_q    <= 1'b0;
      bram_we_q    <= '0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.req_valid) begin
          store_q      <= bus.req_store;
          bram_addr_q  <= bus.req_addr[BRAM_ADDR_WIDTH+1:2];
          bram_wdata_q <= bus.req_wdata << shift;
          req_ready_q  <= 1'b0;
          busy_q       <= 1'b1;
          if (mis) begin
            // Zero mask keeps the byte reader from flagging a valid result.
            state_q      <= S_ERR;
            byte_mask_q  <= '0;
            done_q       <= 1'b1;
            misaligned_q <= 1'b1;
          end else begin
            state_q     <= S_ISSUE;
            byte_mask_q <= mask;
            bram_en_q   <= 1'b1;
            bram_we_q   <= bus.req_store ? mask : 4'b0000;
          end
        end
        S_ISSUE: begin
          if (store_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_WAIT;
            cnt_q   <= 2'(BRAM_LATENCY - 1);
          end
        end
        S_WAIT: begin
          if (cnt_q == 2'd0) begin
            ld_data_q <= bus.bram_rdata;
            state_q   <= S_DONE;
            done_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        S_DONE, S_ERR: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.bram_en    = bram_en_q;
  assign bus.bram_we    = bram_we_q;
  assign bus.bram_addr  = bram_addr_q;
  assign bus.bram_wdata = bram_wdata_q;
  assign bus.ld_data    = ld_data_q;
  assign bus.byte_mask  = byte_mask_q;
  assign bus.done       = done_q;
  assign bus.misaligned = misaligned_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: latency-1 and latency-3 instances,
// each with a small BRAM read model that returns garbage outside the valid cycle.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_WIDTH(32), .BRAM_ADDR_WIDTH(10)) b1 ();
  data_mem_ctrl_if #(.ADDR_WIDTH(32), .BRAM_ADDR_WIDTH(10)) b3 ();

  data_mem_ctrl #(.ADDR_WIDTH(32), .BRAM_ADDR_WIDTH(10), .BRAM_LATENCY(1))
    dut1 (.clk(clk), .rst(rst), .bus(b1));
  data_mem_ctrl #(.ADDR_WIDTH(32), .BRAM_ADDR_WIDTH(10), .BRAM_LATENCY(3))
    dut3 (.clk(clk), .rst(rst), .bus(b3));

  int checks = 0;
  int errors = 0;
  logic [31:0] rd_word1 = 32'h0;
  logic [31:0] rd_word3 = 32'h0;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  // BRAM read models: data valid only in the cycle after the latency elapses
  logic p1 = 1'b0, p2 = 1'b0;
  always @(posedge clk) begin
    b1.bram_rdata <= b1.bram_en ? rd_word1 : JUNK;
    p1 <= b3.bram_en;
    p2 <= p1;
    b3.bram_rdata <= p2 ? rd_word3 : JUNK;
  end

  // bram_en must never be high on two consecutive cycles
  logic en_prev = 1'b0;
  int   en_dbl  = 0;
  always @(negedge clk) begin
    if (b1.bram_en && en_prev) en_dbl++;
    en_prev = b1.bram_en;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic req1(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    b1.req_valid = 1'b1; b1.req_store = st; b1.req_func3 = f3; b1.req_addr = a; b1.req_wdata = wd;
  endtask

  task automatic test_reset();
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    checks++; if (b1.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", b1.req_ready); end
    checks++; if (b1.bram_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b exp 0", b1.bram_en); end
    checks++; if (b1.done !== 1'b0 || b1.busy !== 1'b0 || b1.misaligned !== 1'b0) begin errors++; $display("FAIL rst_flags got done=%b busy=%b mis=%b exp 0", b1.done, b1.busy, b1.misaligned); end
    checks++; if (b1.ld_data !== 32'h0 || b1.byte_mask !== 4'h0 || b1.bram_we !== 4'h0) begin errors++; $display("FAIL rst_data got ld=%h mask=%b we=%b exp 0", b1.ld_data, b1.byte_mask, b1.bram_we); end
    checks++; if (b3.req_ready !== 1'b1 || b3.busy !== 1'b0) begin errors++; $display("FAIL rst_b3 got ready=%b busy=%b exp 1/0", b3.req_ready, b3.busy); end
  endtask

  task automatic test_load_word();
    rd_word1 = 32'hDEAD_BEEF;
    req1(1'b0, F3_LW, 32'h10, 32'h0);
    cyc(); b1.req_valid = 1'b0;  // T1
    checks++; if (b1.bram_en !== 1'b1 || b1.bram_we !== 4'h0) begin errors++; $display("FAIL lw_issue got en=%b we=%b exp 1/0000", b1.bram_en, b1.bram_we); end
    checks++; if (b1.bram_addr !== 10'h004) begin errors++; $display("FAIL lw_addr got %h exp 004", b1.bram_addr); end
    checks++; if (b1.busy !== 1'b1 || b1.req_ready !== 1'b0 || b1.done !== 1'b0) begin errors++; $display("FAIL lw_t1 got busy=%b ready=%b done=%b exp 1/0/0", b1.busy, b1.req_ready, b1.done); end
    cyc();  // T2
    checks++; if (b1.bram_en !== 1'b0 || b1.done !== 1'b0) begin errors++; $display("FAIL lw_t2 got en=%b done=%b exp 0/0", b1.bram_en, b1.done); end
    cyc();  // T3
    checks++; if (b1.done !== 1'b1 || b1.misaligned !== 1'b0) begin errors++; $display("FAIL lw_done got done=%b mis=%b exp 1/0", b1.done, b1.misaligned); end
    checks++; if (b1.ld_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", b1.ld_data); end
    checks++; if (b1.byte_mask !== 4'b1111) begin errors++; $display("FAIL lw_mask got %b exp 1111", b1.byte_mask); end
    cyc();  // T4
    checks++; if (b1.done !== 1'b0 || b1.req_ready !== 1'b1 || b1.busy !== 1'b0) begin errors++; $display("FAIL lw_idle got done=%b ready=%b busy=%b exp 0/1/0", b1.done, b1.req_ready, b1.busy); end
    checks++; if (b1.ld_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_hold got %h exp deadbeef", b1.ld_data); end
  endtask

  task automatic test_store_byte();
    req1(1'b1, F3_SB, 32'h23, 32'h0000_00A5);
    cyc(); b1.req_valid = 1'b0;  // T1
    checks++; if (b1.bram_en !== 1'b1 || b1.bram_we !== 4'b1000) begin errors++; $display("FAIL sb_we got en=%b we=%b exp 1/1000", b1.bram_en, b1.bram_we); end
    checks++; if (b1.bram_wdata !== 32'hA500_0000) begin errors++; $display("FAIL sb_wdata got %h exp a5000000", b1.bram_wdata); end
    checks++; if (b1.bram_addr !== 10'h008) begin errors++; $display("FAIL sb_addr got %h exp 008", b1.bram_addr); end
    cyc();  // T2
    checks++; if (b1.done !== 1'b1 || b1.bram_en !== 1'b0 || b1.bram_we !== 4'h0) begin errors++; $display("FAIL sb_done got done=%b en=%b we=%b exp 1/0/0000", b1.done, b1.bram_en, b1.bram_we); end
    checks++; if (b1.ld_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sb_ldhold got %h exp deadbeef", b1.ld_data); end
    cyc();  // T3
    checks++; if (b1.req_ready !== 1'b1 || b1.done !== 1'b0) begin errors++; $display("FAIL sb_idle got ready=%b done=%b exp 1/0", b1.req_ready, b1.done); end
    // Half store at lane 2
    req1(1'b1, F3_SH, 32'h0000_1006, 32'hFFFF_BEEF);
    cyc(); b1.req_valid = 1'b0;
    checks++; if (b1.bram_we !== 4'b1100 || b1.bram_wdata !== 32'hBEEF_0000 || b1.bram_addr !== 10'h001) begin errors++; $display("FAIL sh_issue got we=%b wd=%h addr=%h exp 1100/beef0000/001", b1.bram_we, b1.bram_wdata, b1.bram_addr); end
    cyc(); cyc();
  endtask

  task automatic test_misaligned();
    logic [2:0] f3s [3];
    logic [31:0] as [3];
    f3s[0] = F3_LH; as[0] = 32'h41;
    f3s[1] = F3_LW; as[1] = 32'h42;
    f3s[2] = 3'b011; as[2] = 32'h40;  // undefined code, aligned
    for (int i = 0; i < 3; i++) begin
      req1(1'b0, f3s[i], as[i], 32'h0);
      cyc(); b1.req_valid = 1'b0;  // T1
      checks++; if (b1.done !== 1'b1 || b1.misaligned !== 1'b1) begin errors++; $display("FAIL mis%0d_pulse got done=%b mis=%b exp 1/1", i, b1.done, b1.misaligned); end
      checks++; if (b1.bram_en !== 1'b0 || b1.bram_we !== 4'h0 || b1.byte_mask !== 4'h0) begin errors++; $display("FAIL mis%0d_bram got en=%b we=%b mask=%b exp 0", i, b1.bram_en, b1.bram_we, b1.byte_mask); end
      cyc();  // T2
      checks++; if (b1.done !== 1'b0 || b1.misaligned !== 1'b0 || b1.req_ready !== 1'b1 || b1.busy !== 1'b0 || b1.bram_en !== 1'b0) begin errors++; $display("FAIL mis%0d_idle got done=%b mis=%b ready=%b busy=%b en=%b exp 0/0/1/0/0", i, b1.done, b1.misaligned, b1.req_ready, b1.busy, b1.bram_en); end
    end
  endtask

  task automatic test_reset_mid();
    int seen_done = 0;
    rd_word1 = 32'h1111_2222;
    req1(1'b0, F3_LW, 32'h20, 32'h0);
    cyc(); b1.req_valid = 1'b0;  // T1
    cyc();                        // T2, WAIT
    rst = 1'b1; #1;
    checks++; if (b1.busy !== 1'b0 || b1.req_ready !== 1'b1 || b1.bram_en !== 1'b0 || b1.done !== 1'b0) begin errors++; $display("FAIL rmid_clear got busy=%b ready=%b en=%b done=%b exp 0/1/0/0", b1.busy, b1.req_ready, b1.bram_en, b1.done); end
    checks++; if (b1.byte_mask !== 4'h0 || b1.ld_data !== 32'h0) begin errors++; $display("FAIL rmid_data got mask=%b ld=%h exp 0/0", b1.byte_mask, b1.ld_data); end
    cyc(); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (b1.done === 1'b1 || b1.bram_en === 1'b1) seen_done++;
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL rmid_nodone got %0d active cycles exp 0", seen_done); end
    rd_word1 = 32'h1234_5678;
    req1(1'b0, F3_LW, 32'h30, 32'h0);
    cyc(); b1.req_valid = 1'b0;
    checks++; if (b1.bram_en !== 1'b1 || b1.bram_addr !== 10'h00C) begin errors++; $display("FAIL rmid_reissue got en=%b addr=%h exp 1/00c", b1.bram_en, b1.bram_addr); end
    cyc(); cyc();  // T3
    checks++; if (b1.done !== 1'b1 || b1.ld_data !== 32'h1234_5678) begin errors++; $display("FAIL rmid_next got done=%b ld=%h exp 1/12345678", b1.done, b1.ld_data); end
    cyc();
  endtask

  task automatic test_latency3();
    int n_done = 0;
    logic [31:0] wb;
    rd_word3 = 32'h8001_1234;
    b3.req_valid = 1'b1; b3.req_store = 1'b0; b3.req_func3 = F3_LHU; b3.req_addr = 32'h06; b3.req_wdata = 32'h0;
    cyc(); b3.req_valid = 1'b0;  // T1
    checks++; if (b3.bram_en !== 1'b1 || b3.bram_addr !== 10'h001) begin errors++; $display("FAIL l3_issue got en=%b addr=%h exp 1/001", b3.bram_en, b3.bram_addr); end
    for (int t = 1; t <= 10 && n_done == 0; t++) begin
      if (b3.done === 1'b1) n_done = t;
      else cyc();
    end
    checks++; if (n_done !== 5) begin errors++; $display("FAIL l3_latency got T%0d exp T5 (0 = timeout)", n_done); end
    checks++; if (b3.byte_mask !== 4'b1100) begin errors++; $display("FAIL l3_mask got %b exp 1100", b3.byte_mask); end
    checks++; if (b3.ld_data !== 32'h8001_1234) begin errors++; $display("FAIL l3_data got %h exp 80011234", b3.ld_data); end
    wb = {16'h0, b3.ld_data[31:16]};
    checks++; if (wb !== 32'h0000_8001) begin errors++; $display("FAIL l3_wb got %h exp 00008001", wb); end
    cyc(); cyc();
  endtask

  task automatic test_back_to_back();
    rd_word1 = 32'hCAFE_5A00;
    req1(1'b1, F3_SW, 32'h0C, 32'h1122_3344);
    cyc();  // T1
    checks++; if (b1.bram_en !== 1'b1 || b1.bram_we !== 4'b1111 || b1.bram_wdata !== 32'h1122_3344 || b1.bram_addr !== 10'h003) begin errors++; $display("FAIL b2b_sw got en=%b we=%b wd=%h addr=%h exp 1/1111/11223344/003", b1.bram_en, b1.bram_we, b1.bram_wdata, b1.bram_addr); end
    cyc();  // T2
    checks++; if (b1.done !== 1'b1) begin errors++; $display("FAIL b2b_sw_done got %b exp 1", b1.done); end
    req1(1'b0, F3_LB, 32'h0D, 32'h0);
    cyc();  // T3, IDLE with valid still high
    checks++; if (b1.req_ready !== 1'b1 || b1.busy !== 1'b0 || b1.bram_en !== 1'b0) begin errors++; $display("FAIL b2b_gap got ready=%b busy=%b en=%b exp 1/0/0", b1.req_ready, b1.busy, b1.bram_en); end
    cyc(); b1.req_valid = 1'b0;  // T4
    checks++; if (b1.bram_en !== 1'b1 || b1.bram_we !== 4'h0 || b1.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_lb_issue got en=%b we=%b ready=%b exp 1/0000/0", b1.bram_en, b1.bram_we, b1.req_ready); end
    cyc(); cyc();  // T6
    checks++; if (b1.done !== 1'b1 || b1.ld_data !== 32'hCAFE_5A00 || b1.byte_mask !== 4'b0010) begin errors++; $display("FAIL b2b_lb_done got done=%b ld=%h mask=%b exp 1/cafe5a00/0010", b1.done, b1.ld_data, b1.byte_mask); end
    cyc();
    checks++; if (en_dbl !== 0) begin errors++; $display("FAIL b2b_en_twice got %0d exp 0", en_dbl); end
  endtask

  initial begin
    b1.req_valid = 1'b0; b1.req_store = 1'b0; b1.req_func3 = 3'b0; b1.req_addr = 32'h0; b1.req_wdata = 32'h0;
    b3.req_valid = 1'b0; b3.req_store = 1'b0; b3.req_func3 = 3'b0; b3.req_addr = 32'h0; b3.req_wdata = 32'h0;
    test_reset();
    test_load_word();
    test_store_byte();
    test_misaligned();
    test_reset_mid();
    test_latency3();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
